reg_bank_rd: RTL and testbench

Parametrised register bank with two registered, selectable read ports. It replaces the purely combinational 16-way 16-bit select in the CPU datapath with a storage array plus read muxes. It adds configurable width and depth, a one-cycle registered read, same-cycle write-to-read bypass, and an optional hard-wired zero entry. It sits between the writeback stage and the ALU operand inputs.

---
 rtl/reg_bank_rd.sv | 101 ++++++++++
 tb/tb_reg_bank_rd.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_rd.sv
// reg_bank_rd: DEPTH x WIDTH flop register bank with two independently selected,
// registered read ports, same-edge write-to-read bypass and an optional zero entry.
module reg_bank_rd #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int ZERO_REG = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_en,
  input  logic [AW-1:0]    sel_a,
  input  logic [AW-1:0]    sel_b,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_valid
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0] wr_sel_s;
  logic             wr_ok_s;
  logic [WIDTH-1:0] rd_a_s;
  logic [WIDTH-1:0] rd_b_s;

  function automatic logic is_zero_entry(input logic [AW-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  // Selects with no matching entry fall through to zero; the bypass only fires
  // for writes that will actually land, so dropped writes are never forwarded.
  function automatic logic [WIDTH-1:0] port_value(input logic [AW-1:0] sel);
    logic [WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel == AW'(i)) begin
        v = mem_r[i];
      end
    end
    if (wr_ok_s && (waddr == sel)) begin
      v = wdata;
    end
    if (is_zero_entry(sel)) begin
      v = '0;
    end
    return v;
  endfunction

  // Write decode: one-hot entry enable, empty for out-of-range or zero-entry writes
  always_comb begin
    wr_sel_s = '0;
    wr_ok_s  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (we && (waddr == AW'(i)) && !is_zero_entry(waddr)) begin
        wr_sel_s[i] = 1'b1;
        wr_ok_s     = 1'b1;
      end else begin
        wr_sel_s[i] = 1'b0;
      end
    end
  end

  // Read data presented to the output flops
  always_comb begin
    rd_a_s = port_value(sel_a);
    rd_b_s = port_value(sel_b);
  end

  // Storage array
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_sel_s[i]) begin
          mem_r[i] <= wdata;
        end
      end
    end
  end

  // Output stage: capture on rd_en, otherwise hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_a     <= '0;
      out_b     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= rd_en;
      if (rd_en) begin
        out_a <= rd_a_s;
        out_b <= rd_b_s;
      end
    end
  end

endmodule

// File: tb/tb_reg_bank_rd.sv
// tb_reg_bank_rd: drives three reg_bank_rd configurations (default, ZERO_REG=1,
// DEPTH=10/WIDTH=32) from shared stimulus and compares against an array model.
module tb_reg_bank_rd;

  logic        clk;
  logic        reset;
  logic        we;
  logic [3:0]  waddr;
  logic [31:0] wdata;
  logic        rd_en;
  logic [3:0]  sel_a;
  logic [3:0]  sel_b;

  logic [15:0] a0, b0, a1, b1;
  logic [31:0] a2, b2;
  logic        v0, v1, v2;

  logic [31:0] oa [3];
  logic [31:0] ob [3];
  logic        ov [3];

  // model state
  logic [31:0] mem [3][16];
  logic [31:0] ea [3];
  logic [31:0] eb [3];
  logic        ev;
  int          dep [3] = '{16, 16, 10};
  int          zr  [3] = '{0, 1, 0};
  logic [31:0] msk [3] = '{32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFF_FFFF};

  int checks = 0;
  int errors = 0;

  reg_bank_rd #(.WIDTH(16), .DEPTH(16), .AW(4), .ZERO_REG(0)) u_def (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata[15:0]),
    .rd_en(rd_en), .sel_a(sel_a), .sel_b(sel_b),
    .out_a(a0), .out_b(b0), .out_valid(v0));

  reg_bank_rd #(.WIDTH(16), .DEPTH(16), .AW(4), .ZERO_REG(1)) u_zero (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata[15:0]),
    .rd_en(rd_en), .sel_a(sel_a), .sel_b(sel_b),
    .out_a(a1), .out_b(b1), .out_valid(v1));

  reg_bank_rd #(.WIDTH(32), .DEPTH(10), .AW(4), .ZERO_REG(0)) u_d10 (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .rd_en(rd_en), .sel_a(sel_a), .sel_b(sel_b),
    .out_a(a2), .out_b(b2), .out_valid(v2));

  always #5 clk = ~clk;

  always_comb begin
    oa[0] = {16'h0000, a0}; ob[0] = {16'h0000, b0}; ov[0] = v0;
    oa[1] = {16'h0000, a1}; ob[1] = {16'h0000, b1}; ov[1] = v1;
    oa[2] = a2;             ob[2] = b2;             ov[2] = v2;
  end

  function automatic logic [31:0] ref_val(int k, logic [3:0] s);
    int si = int'(s);
    if (si >= dep[k]) return 32'h0;
    if (zr[k] != 0 && si == 0) return 32'h0;
    if (we && waddr == s) return wdata & msk[k];
    return mem[k][si];
  endfunction

  function automatic logic write_lands(int k);
    return we && (int'(waddr) < dep[k]) && !(zr[k] != 0 && waddr == 4'd0);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++) mem[k][i] = 32'h0;
      ea[k] = 32'h0;
      eb[k] = 32'h0;
    end
    ev = 1'b0;
  endtask

  // one clock edge: predict from pre-edge model, then commit
  task automatic step();
    logic [31:0] na [3];
    logic [31:0] nb [3];
    logic        wl [3];
    for (int k = 0; k < 3; k++) begin
      na[k] = ref_val(k, sel_a);
      nb[k] = ref_val(k, sel_b);
      wl[k] = write_lands(k);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (rd_en) begin
        ea[k] = na[k];
        eb[k] = nb[k];
      end
      if (wl[k]) mem[k][waddr] = wdata & msk[k];
    end
    ev = rd_en;
  endtask

  task automatic drive(input logic w, input logic [3:0] wa, input logic [31:0] wd,
                       input logic r, input logic [3:0] sa, input logic [3:0] sb);
    we = w; waddr = wa; wdata = wd; rd_en = r; sel_a = sa; sel_b = sb;
  endtask

  task automatic test_reset();
    #3;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (oa[k] !== 32'h0 || ob[k] !== 32'h0 || ov[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_initial inst%0d got a=%h b=%h v=%b want 0", k, oa[k], ob[k], ov[k]);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 4'd5, 32'h0000_1234, 1'b0, 4'd0, 4'd0);
    step();
    drive(1'b0, 4'd0, 32'h0, 1'b1, 4'd5, 4'd5);
    step();
    checks++;
    if (oa[0] !== 32'h1234 || ob[0] !== 32'h1234) begin
      errors++;
      $display("FAIL reset_preload got a=%h b=%h want 1234", oa[0], ob[0]);
    end
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (oa[k] !== 32'h0 || ob[k] !== 32'h0 || ov[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_async inst%0d got a=%h b=%h v=%b want 0", k, oa[k], ob[k], ov[k]);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 4'd0, 32'h0, 1'b1, 4'd5, 4'd5);
    step();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (oa[k] !== 32'h0 || ob[k] !== 32'h0 || ov[k] !== 1'b1) begin
        errors++;
        $display("FAIL reset_cleared_entry inst%0d got a=%h b=%h v=%b want 0/0/1", k, oa[k], ob[k], ov[k]);
      end
    end
  endtask

  task automatic test_basic();
    drive(1'b1, 4'd3, 32'h0000_A5A5, 1'b0, 4'd0, 4'd0);
    step();
    drive(1'b1, 4'd12, 32'h0000_5A5A, 1'b0, 4'd0, 4'd0);
    step();
    drive(1'b0, 4'd0, 32'h0, 1'b1, 4'd3, 4'd12);
    step();
    checks++;
    if (oa[0] !== 32'hA5A5 || ob[0] !== 32'h5A5A || ov[0] !== 1'b1) begin
      errors++;
      $display("FAIL basic_read got a=%h b=%h v=%b want a5a5/5a5a/1", oa[0], ob[0], ov[0]);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (oa[k] !== ea[k] || ob[k] !== eb[k] || ov[k] !== ev) begin
        errors++;
        $display("FAIL basic_model inst%0d got a=%h b=%h v=%b want %h/%h/%b", k, oa[k], ob[k], ov[k], ea[k], eb[k], ev);
      end
    end
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd1, 4'd2);
    step();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (oa[k] !== ea[k] || ob[k] !== eb[k] || ov[k] !== 1'b0) begin
        errors++;
        $display("FAIL basic_hold inst%0d got a=%h b=%h v=%b want %h/%h/0", k, oa[k], ob[k], ov[k], ea[k], eb[k]);
      end
    end
  endtask

  task automatic test_bypass();
    drive(1'b1, 4'd7, 32'h0000_0001, 1'b0, 4'd0, 4'd0);
    step();
    drive(1'b1, 4'd7, 32'h0000_BEEF, 1'b1, 4'd7, 4'd7);
    step();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (oa[k] !== 32'hBEEF || ob[k] !== 32'hBEEF || ov[k] !== 1'b1) begin
        errors++;
        $display("FAIL bypass_same_edge inst%0d got a=%h b=%h v=%b want beef/beef/1", k, oa[k], ob[k], ov[k]);
      end
    end
    drive(1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 4'd0);
    step();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (oa[k] !== 32'hBEEF || ob[k] !== eb[k]) begin
        errors++;
        $display("FAIL bypass_stored inst%0d got a=%h b=%h want beef/%h", k, oa[k], ob[k], eb[k]);
      end
    end
  endtask

  task automatic test_zero_reg();
    drive(1'b1, 4'd0, 32'h0000_FFFF, 1'b0, 4'd0, 4'd0);
    step();
    drive(1'b0, 4'd0, 32'h0, 1'b1, 4'd0, 4'd0);
    step();
    checks++;
    if (oa[1] !== 32'h0 || oa[0] !== 32'hFFFF) begin
      errors++;
      $display("FAIL zero_reg_read got zero_inst=%h plain_inst=%h want 0/ffff", oa[1], oa[0]);
    end
    drive(1'b1, 4'd0, 32'h0000_1357, 1'b1, 4'd0, 4'd0);
    step();
    checks++;
    if (oa[1] !== 32'h0 || ob[1] !== 32'h0 || oa[0] !== 32'h1357) begin
      errors++;
      $display("FAIL zero_reg_bypass got zero_inst=%h/%h plain_inst=%h want 0/0/1357", oa[1], ob[1], oa[0]);
    end
  endtask

  task automatic test_depth10();
    drive(1'b1, 4'd12, 32'h1234_5678, 1'b0, 4'd0, 4'd0);
    step();
    drive(1'b1, 4'd9, 32'hDEAD_BEEF, 1'b0, 4'd0, 4'd0);
    step();
    drive(1'b0, 4'd0, 32'h0, 1'b1, 4'd12, 4'd9);
    step();
    checks++;
    if (oa[2] !== 32'h0 || ob[2] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL depth10_range got a=%h b=%h want 0/deadbeef", oa[2], ob[2]);
    end
    checks++;
    if (oa[0] !== 32'h5678) begin
      errors++;
      $display("FAIL depth16_entry12 got a=%h want 5678", oa[0]);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'(i), 32'(i) * 32'h0101, 1'b0, 4'd0, 4'd0);
      step();
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 4'd0, 32'h0, 1'b1, 4'(i), 4'(15 - i));
      step();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (oa[k] !== ea[k] || ob[k] !== eb[k] || ov[k] !== 1'b1) begin
          errors++;
          $display("FAIL stream step%0d inst%0d got a=%h b=%h v=%b want %h/%h/1", i, k, oa[k], ob[k], ov[k], ea[k], eb[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
            1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 5) == 0) sel_b = sel_a;
      if ($urandom_range(0, 5) == 0) waddr = sel_a;
      step();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (oa[k] !== ea[k] || ob[k] !== eb[k] || ov[k] !== ev) begin
          errors++;
          $display("FAIL random cyc%0d inst%0d got a=%h b=%h v=%b want %h/%h/%b", n, k, oa[k], ob[k], ov[k], ea[k], eb[k], ev);
        end
      end
      if ($urandom_range(0, 39) == 0) begin
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        for (int k = 0; k < 3; k++) begin
          checks++;
          if (oa[k] !== 32'h0 || ob[k] !== 32'h0 || ov[k] !== 1'b0) begin
            errors++;
            $display("FAIL random_reset cyc%0d inst%0d got a=%h b=%h v=%b want 0", n, k, oa[k], ob[k], ov[k]);
          end
        end
        @(negedge clk);
        reset = 1'b0;
      end
    end
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b1;
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd0);
    model_clear();
    test_reset();
    test_basic();
    test_bypass();
    test_zero_reg();
    test_depth10();
    test_stream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
